// File: rtl/sort_stream_adapter_pkg.sv
// Shared types and default sizing for the sorter stream adapter.
package sort_pkg;

  localparam int DEPTH  = 8;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 3;

  typedef enum logic [2:0] {
    LOAD,
    START,
    SORT,
    RD_ADDR,
    RD_CAP,
    SEND
  } state_t;

endpackage

// File: rtl/sort_stream_adapter.sv
// Streams a batch of DEPTH elements into the selection sorter, triggers it,
// then streams the sorted contents back out with a last flag.
module sort_stream_adapter #(
  parameter int DATA_W = sort_pkg::DATA_W,
  parameter int DEPTH  = sort_pkg::DEPTH,
  parameter int ADDR_W = sort_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              srt_start,
  output logic              srt_wr,
  output logic [ADDR_W-1:0] srt_addr,
  output logic [DATA_W-1:0] srt_datain,
  input  logic [DATA_W-1:0] srt_dataout,
  input  logic              srt_ready
);

  import sort_pkg::*;

  localparam logic [ADDR_W:0] CNT_LAST = (ADDR_W+1)'(DEPTH-1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W:0]     r_cnt;
  logic                r_out_valid;
  logic                r_out_last;
  logic [DATA_W-1:0]   r_out_data;
  logic                w_in_fire;
  logic                w_out_fire;
  logic                w_cnt_last;

  assign w_cnt_last = (r_cnt == CNT_LAST);
  assign in_ready   = (r_state == LOAD) && srt_ready;
  assign w_in_fire  = in_valid && in_ready;
  assign w_out_fire = (r_state == SEND) && r_out_valid && out_ready;

  assign srt_wr     = w_in_fire;
  assign srt_start  = (r_state == START);
  assign srt_addr   = r_cnt[ADDR_W-1:0];
  assign srt_datain = in_data;
  assign busy       = (r_state != LOAD);

  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign out_last   = r_out_last;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) r_state <= LOAD;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      LOAD:    if (w_in_fire && w_cnt_last) w_state_nxt = START;
      START:   w_state_nxt = SORT;
      SORT:    if (srt_ready) w_state_nxt = RD_ADDR;
      RD_ADDR: w_state_nxt = RD_CAP;
      RD_CAP:  w_state_nxt = SEND;
      SEND:    if (w_out_fire) w_state_nxt = w_cnt_last ? LOAD : RD_ADDR;
      default: w_state_nxt = LOAD;
    endcase
  end

  // srt_dataout is registered in the sorter: RD_ADDR presents the address,
  // RD_CAP takes the data one cycle later.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_data  <= '0;
    end else begin
      case (r_state)
        LOAD: begin
          if (w_in_fire) r_cnt <= w_cnt_last ? '0 : r_cnt + 1'b1;
        end
        RD_CAP: begin
          r_out_data  <= srt_dataout;
          r_out_valid <= 1'b1;
          r_out_last  <= w_cnt_last;
        end
        SEND: begin
          if (w_out_fire) begin
            r_out_valid <= 1'b0;
            if (w_cnt_last) begin
              r_cnt      <= '0;
              r_out_last <= 1'b0;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sort_stream_adapter.sv
// Directed bench for sort_stream_adapter with a behavioural sorter beside it.
module tb_sort_stream_adapter;

  typedef logic [7:0] arr_t [8];

  logic       clk = 1'b0;
  logic       nrst;
  logic       in_valid, in_ready, out_valid, out_ready, out_last, busy;
  logic [7:0] in_data, out_data, srt_datain, srt_dataout;
  logic       srt_start, srt_wr, srt_ready;
  logic [2:0] srt_addr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sort_stream_adapter #(.DATA_W(8), .DEPTH(8), .ADDR_W(3)) dut (
    .clk(clk), .nrst(nrst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .srt_start(srt_start), .srt_wr(srt_wr), .srt_addr(srt_addr),
    .srt_datain(srt_datain), .srt_dataout(srt_dataout), .srt_ready(srt_ready)
  );

  // Behavioural sorter: registered read, ready drops on start, sorts after a delay.
  arr_t mem;
  int   s_timer;

  function automatic arr_t sort8(input arr_t a);
    arr_t   r;
    logic [7:0] tmp;
    r = a;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 7 - i; j++)
        if (r[j] > r[j+1]) begin tmp = r[j]; r[j] = r[j+1]; r[j+1] = tmp; end
    return r;
  endfunction

  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      srt_ready   <= 1'b1;
      s_timer     <= 0;
      srt_dataout <= 8'h00;
    end else begin
      if (srt_wr) mem[srt_addr] <= srt_datain;
      else        srt_dataout   <= mem[srt_addr];
      if (srt_start) begin
        srt_ready <= 1'b0;
        s_timer   <= 6;
      end else if (!srt_ready) begin
        if (s_timer == 1) begin
          mem       <= sort8(mem);
          srt_ready <= 1'b1;
        end
        s_timer <= s_timer - 1;
      end
    end
  end

  // Write / start monitors
  int         wr_cnt = 0, start_cnt = 0, start_dbl = 0;
  logic [2:0] wr_log [64];
  logic       start_prev = 1'b0;

  always @(posedge clk) begin
    if (srt_wr) begin
      wr_log[wr_cnt % 64] <= srt_addr;
      wr_cnt <= wr_cnt + 1;
    end
    if (srt_start) start_cnt <= start_cnt + 1;
    if (srt_start && start_prev) start_dbl <= start_dbl + 1;
    start_prev <= srt_start;
  end

  task automatic load_batch(input arr_t v, input bit gaps, input bit keep_valid, output bit ok);
    int t;
    ok = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_data  = v[i];
      t = 0;
      while (!in_ready && t < 200) begin @(posedge clk); #1; t++; end
      if (t >= 200) ok = 1'b0;
      @(posedge clk); #1;
      if (gaps && i < 7) begin
        in_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
      end
    end
    if (keep_valid) in_data = 8'hAA;
    else            in_valid = 1'b0;
  endtask

  task automatic test_reset();
    nrst = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b1;
    #12;
    checks++;
    if ({out_valid, out_last, busy, srt_start, srt_wr} !== 5'b0 || out_data !== 8'h00 || srt_addr !== 3'd0) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%b last=%b busy=%b start=%b wr=%b data=%0d addr=%0d, want all 0",
               out_valid, out_last, busy, srt_start, srt_wr, out_data, srt_addr);
    end
    @(posedge clk); #1; nrst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_idle: in_ready=%b busy=%b, want 1 0", in_ready, busy);
    end
  endtask

  task automatic test_basic();
    arr_t exp = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7};
    bit ok; int t; int s0, w0;
    s0 = start_cnt; w0 = wr_cnt;
    out_ready = 1'b1;
    load_batch('{8'd5, 8'd3, 8'd7, 8'd1, 8'd0, 8'd6, 8'd2, 8'd4}, 1'b0, 1'b0, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL basic_load: in_ready timeout"); end
    for (int k = 0; k < 8; k++) begin
      t = 0;
      while (!out_valid && t < 200) begin @(posedge clk); #1; t++; end
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp[k] || out_last !== (k == 7)) begin
        errors++;
        $display("FAIL basic_out[%0d]: valid=%b data=%0d last=%b, want 1 %0d %b", k, out_valid, out_data, out_last, exp[k], k == 7);
      end
      if (k > 0) begin
        checks++;
        if (t !== 2) begin errors++; $display("FAIL basic_spacing[%0d]: idle cycles=%0d, want 2", k, t); end
      end
      @(posedge clk); #1;
    end
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL basic_return: in_ready=%b busy=%b out_valid=%b, want 1 0 0", in_ready, busy, out_valid);
    end
    checks++;
    if (start_cnt - s0 !== 1 || start_dbl !== 0) begin
      errors++; $display("FAIL basic_start: pulses=%0d double=%0d, want 1 0", start_cnt - s0, start_dbl);
    end
    checks++;
    if (wr_cnt - w0 !== 8) begin errors++; $display("FAIL basic_writes: got %0d, want 8", wr_cnt - w0); end
  endtask

  task automatic test_stall();
    arr_t exp = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7};
    bit ok; int t;
    out_ready = 1'b1;
    load_batch('{8'd5, 8'd3, 8'd7, 8'd1, 8'd0, 8'd6, 8'd2, 8'd4}, 1'b0, 1'b0, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL stall_load: in_ready timeout"); end
    for (int k = 0; k < 8; k++) begin
      t = 0;
      while (!out_valid && t < 200) begin @(posedge clk); #1; t++; end
      if (k == 3) begin
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
          @(posedge clk); #1;
          checks++;
          if (out_valid !== 1'b1 || out_data !== 8'd3 || out_last !== 1'b0) begin
            errors++;
            $display("FAIL stall_hold[%0d]: valid=%b data=%0d last=%b, want 1 3 0", c, out_valid, out_data, out_last);
          end
        end
        out_ready = 1'b1;
      end
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp[k] || out_last !== (k == 7)) begin
        errors++;
        $display("FAIL stall_out[%0d]: valid=%b data=%0d last=%b, want 1 %0d %b", k, out_valid, out_data, out_last, exp[k], k == 7);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_gaps();
    arr_t exp = '{8'd0, 8'd1, 8'd1, 8'd9, 8'd9, 8'd9, 8'd200, 8'd255};
    bit ok; int t; int w0;
    w0 = wr_cnt;
    out_ready = 1'b1;
    load_batch('{8'd9, 8'd9, 8'd1, 8'd200, 8'd9, 8'd0, 8'd255, 8'd1}, 1'b1, 1'b0, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL gaps_load: in_ready timeout"); end
    @(posedge clk); #1;
    checks++;
    if (wr_cnt - w0 !== 8) begin errors++; $display("FAIL gaps_writes: got %0d, want 8", wr_cnt - w0); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (wr_log[(w0 + i) % 64] !== 3'(i)) begin
        errors++; $display("FAIL gaps_addr[%0d]: got %0d, want %0d", i, wr_log[(w0 + i) % 64], i);
      end
    end
    for (int k = 0; k < 8; k++) begin
      t = 0;
      while (!out_valid && t < 200) begin @(posedge clk); #1; t++; end
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp[k] || out_last !== (k == 7)) begin
        errors++;
        $display("FAIL gaps_out[%0d]: valid=%b data=%0d last=%b, want 1 %0d %b", k, out_valid, out_data, out_last, exp[k], k == 7);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid_sort();
    arr_t exp = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
    bit ok; int t;
    out_ready = 1'b1;
    load_batch('{8'd50, 8'd40, 8'd30, 8'd20, 8'd10, 8'd60, 8'd70, 8'd80}, 1'b0, 1'b0, ok);
    repeat (2) begin @(posedge clk); #1; end
    checks++;
    if (!ok || busy !== 1'b1 || srt_ready !== 1'b0) begin
      errors++; $display("FAIL rst_presort: ok=%b busy=%b srt_ready=%b, want 1 1 0", ok, busy, srt_ready);
    end
    nrst = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL rst_mid: out_valid=%b busy=%b in_ready=%b, want 0 0 1", out_valid, busy, in_ready);
    end
    @(posedge clk); #1; nrst = 1'b1;
    load_batch('{8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1}, 1'b0, 1'b0, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL rst_reload: in_ready timeout"); end
    for (int k = 0; k < 8; k++) begin
      t = 0;
      while (!out_valid && t < 200) begin @(posedge clk); #1; t++; end
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp[k] || out_last !== (k == 7)) begin
        errors++;
        $display("FAIL rst_out[%0d]: valid=%b data=%0d last=%b, want 1 %0d %b", k, out_valid, out_data, out_last, exp[k], k == 7);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    arr_t exp_a = '{8'd2, 8'd2, 8'd4, 8'd4, 8'd6, 8'd6, 8'd8, 8'd8};
    arr_t exp_b = '{8'd0, 8'd1, 8'd3, 8'd6, 8'd12, 8'd25, 8'd50, 8'd100};
    bit ok; int t;
    out_ready = 1'b1;
    load_batch('{8'd4, 8'd4, 8'd2, 8'd2, 8'd8, 8'd8, 8'd6, 8'd6}, 1'b0, 1'b0, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL b2b_load_a: in_ready timeout"); end
    for (int k = 0; k < 8; k++) begin
      t = 0;
      while (!out_valid && t < 200) begin @(posedge clk); #1; t++; end
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp_a[k] || out_last !== (k == 7)) begin
        errors++;
        $display("FAIL b2b_a[%0d]: valid=%b data=%0d last=%b, want 1 %0d %b", k, out_valid, out_data, out_last, exp_a[k], k == 7);
      end
      @(posedge clk); #1;
    end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready: got %b, want 1", in_ready); end
    load_batch('{8'd100, 8'd50, 8'd25, 8'd12, 8'd6, 8'd3, 8'd1, 8'd0}, 1'b0, 1'b0, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL b2b_load_b: in_ready timeout"); end
    for (int k = 0; k < 8; k++) begin
      t = 0;
      while (!out_valid && t < 200) begin @(posedge clk); #1; t++; end
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp_b[k] || out_last !== (k == 7)) begin
        errors++;
        $display("FAIL b2b_b[%0d]: valid=%b data=%0d last=%b, want 1 %0d %b", k, out_valid, out_data, out_last, exp_b[k], k == 7);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_valid_while_busy();
    arr_t exp = '{8'd10, 8'd11, 8'd12, 8'd13, 8'd14, 8'd15, 8'd16, 8'd17};
    bit ok; int t; int w0; int bad_rdy;
    w0 = wr_cnt; bad_rdy = 0;
    out_ready = 1'b1;
    load_batch('{8'd17, 8'd16, 8'd15, 8'd14, 8'd13, 8'd12, 8'd11, 8'd10}, 1'b0, 1'b1, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL busy_load: in_ready timeout"); end
    for (int k = 0; k < 8; k++) begin
      t = 0;
      while (!out_valid && t < 200) begin
        if (in_ready !== 1'b0) bad_rdy++;
        @(posedge clk); #1; t++;
      end
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp[k] || out_last !== (k == 7)) begin
        errors++;
        $display("FAIL busy_out[%0d]: valid=%b data=%0d last=%b, want 1 %0d %b", k, out_valid, out_data, out_last, exp[k], k == 7);
      end
      if (in_ready !== 1'b0) bad_rdy++;
      if (k == 7) in_valid = 1'b0;
      @(posedge clk); #1;
    end
    checks++;
    if (bad_rdy !== 0) begin errors++; $display("FAIL busy_in_ready: high in %0d busy cycles, want 0", bad_rdy); end
    checks++;
    if (wr_cnt - w0 !== 8) begin errors++; $display("FAIL busy_writes: got %0d, want 8", wr_cnt - w0); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_gaps();
    test_reset_mid_sort();
    test_back_to_back();
    test_valid_while_busy();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/sort_stream_adapter.md
Name: sort_stream_adapter

Overview:
Streaming front/back end for the 8-entry selection sorter.
- Accepts 8 bytes on a valid/ready input stream and writes them into the sorter through its wr/addr/datain port.
- Pulses start, waits for the sorter's ready to return, then reads the 8 sorted bytes back and emits them in ascending address order on a valid/ready output stream with a last flag.
- Instantiated beside the sorter in the parent; both share clk and nrst.

Parameters:
DATA_W, 8, element width; must match the sorter.
DEPTH, 8, elements per batch; must match the sorter.
ADDR_W, 3, $clog2(DEPTH).

Ports:
clk  input  1  clock, all state updates on posedge.
nrst  input  1  asynchronous active-low reset.
in_valid  input  1  upstream byte valid.
in_ready  output  1  adapter can accept a byte.
in_data  input  DATA_W  upstream byte.
out_valid  output  1  sorted byte valid.
out_ready  input  1  downstream accepts byte.
out_data  output  DATA_W  sorted byte.
out_last  output  1  high with the DEPTH-th output byte.
busy  output  1  high in every state except LOAD.
srt_start  output  1  to sorter start.
srt_wr  output  1  to sorter wr.
srt_addr  output  ADDR_W  to sorter addr.
srt_datain  output  DATA_W  to sorter datain.
srt_dataout  input  DATA_W  from sorter dataout; registered read, valid 1 cycle after srt_addr is presented with srt_wr=0.
srt_ready  input  1  from sorter ready.

Behaviour:
- Reset (async, nrst=0): state=LOAD, cnt=0, out_valid=0, out_last=0, out_data=0, srt_start=0, srt_wr=0, srt_addr=0, busy=0.
- States: LOAD, START, SORT, RD_ADDR, RD_CAP, SEND.
- LOAD:
  - in_ready = srt_ready.
  - On in_valid&&in_ready (combinational): srt_wr=1, srt_addr=cnt, srt_datain=in_data; cnt++ on the edge.
  - On the transfer with cnt==DEPTH-1: cnt<=0, go to START.
  - A gap in in_valid stalls the load without losing position.
- START: srt_start=1 for exactly one cycle, srt_wr=0; go to SORT.
- SORT: srt_start=0. Leave only when srt_ready==1, then go to RD_ADDR. srt_ready is already 0 in the first SORT cycle, so no extra guard is needed.
- RD_ADDR: srt_addr=cnt, srt_wr=0, srt_start=0; go to RD_CAP.
- RD_CAP: out_data<=srt_dataout, out_valid<=1, out_last<=(cnt==DEPTH-1); go to SEND.
- SEND:
  - out_valid, out_data and out_last are held stable until out_ready.
  - On out_valid&&out_ready: out_valid<=0.
  - If cnt==DEPTH-1: cnt<=0, out_last<=0, go to LOAD. Otherwise cnt++, go to RD_ADDR.
- in_ready=0 in every state except LOAD. srt_wr is asserted only in LOAD. srt_start is asserted only in START.
- Latency:
  - Minimum load is DEPTH cycles.
  - Readout is 3 cycles per element with out_ready held high.
  - in_ready reasserts the cycle after the last output transfer.
- Width rules: cnt is ADDR_W+1 bits wide so the terminal compare is unambiguous. srt_addr = cnt[ADDR_W-1:0].
- Boundary behaviour:
  - out_ready already high when out_valid rises: transfer happens in the first SEND cycle.
  - out_ready high outside SEND: ignored.
  - in_valid high outside LOAD: ignored, no write.
  - Duplicate values are passed through unchanged.
- Reset mid-operation returns to LOAD with cnt=0; partial batches are discarded. The sorter resets on the same nrst, and its memory contents are don't-care.

Decomposition:
- Package sort_pkg: state enum (LOAD..SEND), localparams DEPTH=8, DATA_W=8, ADDR_W=3.
- No sub-module: a single FSM plus cnt and the output register.
- The parent instantiates sort_stream_adapter and the sorter side by side.

Test Plan:
- Load 5,3,7,1,0,6,2,4 with in_valid and out_ready held high -> out_data 0,1,2,3,4,5,6,7 in order, out_last only with 7, srt_start high exactly one cycle.
- Same load, out_ready low for 5 cycles while out_data=3 -> out_valid, out_data=3 and out_last=0 held stable; 3 transfers once when out_ready rises, followed by 4.
- in_valid toggling 1,0,0,1,... while loading 9,9,1,200,9,0,255,1 -> exactly 8 writes to addr 0..7; output 0,1,1,9,9,9,200,255.
- nrst pulsed low mid-SORT -> out_valid=0, busy=0, in_ready=1 immediately; a fresh batch 8..1 then yields 1..8.
- Two back-to-back batches -> in_ready=1 the cycle after the first batch's out_last transfer; second batch sorted independently.
- in_valid high during SORT/SEND -> in_ready=0, srt_wr stays 0, sorted output unaffected.
